// File: rtl/map_pkg.sv
// Shared map geometry, tile codes and fetch FSM encoding for the map_RAM clients.
package map_pkg;

  localparam int MAP_ROWS = 30;
  localparam int MAP_COLS = 40;
  localparam int TILE_W   = 4;
  localparam int ROW_W    = MAP_COLS * TILE_W;

  typedef enum logic [TILE_W-1:0] {
    EMPTY      = 4'd0,
    WALL       = 4'd1,
    DOT        = 4'd2,
    PILL       = 4'd3,
    PACMAN     = 4'd4,
    GHOST      = 4'd5,
    GHOST_DOT  = 4'd6,
    GHOST_PILL = 4'd7
  } tile_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPTURE
  } fetch_state_e;

endpackage

// File: rtl/map_tile_mux.sv
// Combinational 40:1 nibble select from a buffered map row; tile 0 sits in the top nibble.
module map_tile_mux
  import map_pkg::*;
(
  input  logic [ROW_W-1:0]  line,
  input  logic [5:0]        tx,
  output logic [TILE_W-1:0] tile
);

  // NOTE: assign a default before the loop so no path leaves tile unassigned (no latch).
  always_comb begin
    tile = '0;
    for (int i = 0; i < MAP_COLS; i++) begin
      if (tx == 6'(i)) tile = line[ROW_W-1-TILE_W*i -: TILE_W];
    end
  end

endmodule

// File: rtl/map_row_fetcher.sv
// Prefetches one map row into a line buffer during hblank and serves one
// registered tile code per pixel to the renderer.
module map_row_fetcher
  import map_pkg::*;
#(
  parameter int RD_LAT   = 2,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              hblank_start,
  input  logic [9:0]        pixel_x,
  // 10 bits wide: the line counter runs up to V_TOTAL-1.
  input  logic [9:0]        pixel_y,
  input  logic [ROW_W-1:0]  rddata,
  output logic [4:0]        rdaddr,
  output logic [TILE_W-1:0] tile_code,
  output logic [3:0]        tile_px,
  output logic [3:0]        tile_py,
  output logic              busy,
  output logic              late_err
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  fetch_state_e      state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [4:0]        rdaddr_n;
  logic [ROW_W-1:0]  line_buf;
  logic [4:0]        buf_row;
  logic              buf_valid;
  logic [10:0]       target;
  logic [4:0]        target_row;
  logic              fetch_req;
  logic              pixel_active;
  logic [TILE_W-1:0] mux_tile;

  // The line after the last vblank line is line 0 of the next frame.
  assign target       = (pixel_y == 10'(V_TOTAL-1)) ? 11'd0 : {1'b0, pixel_y} + 11'd1;
  assign target_row   = target[8:4];
  assign fetch_req    = hblank_start && (target < 11'(V_ACTIVE))
                        && (!buf_valid || (target_row != buf_row));
  assign pixel_active = (pixel_x < 10'(H_ACTIVE)) && (pixel_y < 10'(V_ACTIVE));
  assign busy         = (state != IDLE);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rdaddr_n = rdaddr;
    case (state)
      IDLE: begin
        if (fetch_req) begin
          rdaddr_n = target_row;
          cnt_n    = CNT_W'(RD_LAT-1);
          state_n  = WAIT;
        end
      end
      WAIT: begin
        if (cnt == '0) state_n = CAPTURE;
        else           cnt_n   = cnt - 1'b1;
      end
      CAPTURE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rdaddr <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rdaddr <= rdaddr_n;
    end
  end

  map_tile_mux u_mux (
    .line (line_buf),
    .tx   (pixel_x[9:4]),
    .tile (mux_tile)
  );

  // NOTE: line_buf is flops, not RAM, so it can and does take a reset value; a RAM array would not.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      line_buf  <= '0;
      buf_row   <= 5'h1F;
      buf_valid <= 1'b0;
      tile_code <= '0;
      tile_px   <= '0;
      tile_py   <= '0;
      late_err  <= 1'b0;
    end else begin
      if (state == CAPTURE) begin
        line_buf  <= rddata;
        buf_row   <= rdaddr;
        buf_valid <= 1'b1;
      end
      // A pulse or active pixel arriving mid-fetch means that line is not covered.
      if (busy && (hblank_start || pixel_active)) late_err <= 1'b1;
      tile_code <= (!pixel_active || !buf_valid || busy) ? '0 : mux_tile;
      tile_px   <= pixel_x[3:0];
      tile_py   <= pixel_y[3:0];
    end
  end

endmodule

// File: tb/tb_map_row_fetcher.sv
// Bench for map_row_fetcher: map_RAM port A model plus a row-snapshot reference model.
module tb_map_row_fetcher;

  logic         CLOCK_50 = 1'b0;
  logic         reset;
  logic         hblank_start;
  logic [9:0]   pixel_x;
  logic [9:0]   pixel_y;
  logic [159:0] rddata;
  logic [4:0]   rdaddr;
  logic [3:0]   tile_code;
  logic [3:0]   tile_px;
  logic [3:0]   tile_py;
  logic         busy;
  logic         late_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] mem [30][40];
  logic [4:0] addr_q = '0;

  int         model_row;
  logic [3:0] model_buf [40];

  always #10 CLOCK_50 = ~CLOCK_50;

  map_row_fetcher dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .hblank_start (hblank_start),
    .pixel_x      (pixel_x),
    .pixel_y      (pixel_y),
    .rddata       (rddata),
    .rdaddr       (rdaddr),
    .tile_code    (tile_code),
    .tile_px      (tile_px),
    .tile_py      (tile_py),
    .busy         (busy),
    .late_err     (late_err)
  );

  function automatic logic [159:0] pack_row(input int r);
    logic [159:0] w;
    w = '0;
    for (int i = 0; i < 40; i++) w[159-4*i -: 4] = mem[r][i];
    return w;
  endfunction

  // Port A: address register then output register, two cycles total.
  always @(posedge CLOCK_50) begin
    addr_q <= rdaddr;
    rddata <= (int'(addr_q) < 30) ? pack_row(int'(addr_q)) : '0;
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Pulse hblank_start for line y, then count busy cycles within a bounded window.
  task automatic pulse(input int y, output int nbusy, output logic [4:0] addr);
    pixel_x      = 10'd640;
    pixel_y      = 10'(y);
    hblank_start = 1'b1;
    tick();
    hblank_start = 1'b0;
    addr  = rdaddr;
    nbusy = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy === 1'b1) nbusy++;
      tick();
    end
  endtask

  task automatic test_reset();
    int nb;
    logic [4:0] a;
    reset = 1'b0; hblank_start = 1'b0; pixel_x = 10'd640; pixel_y = 10'd0;
    tick(); tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (rdaddr !== 5'd0) $display("FAIL reset_rdaddr: got %0d want 0", rdaddr); else n_pass++;
    n_checks++; if (late_err !== 1'b0) $display("FAIL reset_late: got %b want 0", late_err); else n_pass++;
    reset = 1'b1;
    tick();
    pixel_y = 10'd15; hblank_start = 1'b1;
    tick();
    hblank_start = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL mid_wait_busy: got %b want 1", busy); else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL async_reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (rdaddr !== 5'd0) $display("FAIL async_reset_rdaddr: got %0d want 0", rdaddr); else n_pass++;
    tick();
    n_checks++; if ({tile_code, tile_px, tile_py, late_err} !== 13'd0)
      $display("FAIL reset_outputs: got code=%0d px=%0d py=%0d late=%b want all 0",
               tile_code, tile_px, tile_py, late_err); else n_pass++;
    reset = 1'b1;
    tick();
    pulse(524, nb, a);
    n_checks++; if (a !== 5'd0) $display("FAIL wrap_rdaddr: got %0d want 0", a); else n_pass++;
    n_checks++; if (nb != 3) $display("FAIL wrap_busy_cycles: got %0d want 3", nb); else n_pass++;
    pulse(524, nb, a);
    n_checks++; if (nb != 0) $display("FAIL row0_cached: got %0d busy cycles want 0", nb); else n_pass++;
  endtask

  task automatic test_skip();
    int nb;
    logic [4:0] a;
    pulse(15, nb, a);
    n_checks++; if (nb != 3 || a !== 5'd1)
      $display("FAIL skip_first_fetch: got busy=%0d addr=%0d want 3 and 1", nb, a); else n_pass++;
    for (int y = 16; y <= 30; y++) begin
      pulse(y, nb, a);
      n_checks++; if (nb != 0 || rdaddr !== 5'd1)
        $display("FAIL skip_line_%0d: got busy=%0d addr=%0d want 0 and 1", y, nb, rdaddr); else n_pass++;
    end
  endtask

  task automatic test_tile_select();
    int nb;
    logic [4:0] a;
    int xs [6]  = '{0, 16, 32, 624, 640, 100};
    int ys [6]  = '{85, 85, 85, 85, 85, 480};
    int exp [6] = '{0, 1, 2, 7, 0, 0};
    pulse(79, nb, a);
    n_checks++; if (nb != 3 || a !== 5'd5)
      $display("FAIL sel_fetch_row5: got busy=%0d addr=%0d want 3 and 5", nb, a); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      pixel_x = 10'(xs[i]); pixel_y = 10'(ys[i]);
      tick();
      n_checks++; if (tile_code !== 4'(exp[i]))
        $display("FAIL sel_x%0d_y%0d: got %0d want %0d", xs[i], ys[i], tile_code, exp[i]); else n_pass++;
    end
    pixel_x = 10'd37; pixel_y = 10'd85;
    tick();
    n_checks++; if ({tile_code, tile_px, tile_py} !== {4'd2, 4'd5, 4'd5})
      $display("FAIL sel_align: got code=%0d px=%0d py=%0d want 2 5 5", tile_code, tile_px, tile_py);
    else n_pass++;
    n_checks++; if (late_err !== 1'b0) $display("FAIL sel_no_late: got %b want 0", late_err); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nb;
    pixel_x = 10'd640; pixel_y = 10'd223; hblank_start = 1'b1;
    tick();
    nb = (busy === 1'b1) ? 1 : 0;
    pixel_y = 10'd239;
    tick();
    hblank_start = 1'b0;
    n_checks++; if (rdaddr !== 5'd14) $display("FAIL b2b_rdaddr: got %0d want 14", rdaddr); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      if (busy === 1'b1) nb++;
      tick();
    end
    n_checks++; if (nb != 3) $display("FAIL b2b_one_capture: got %0d busy cycles want 3", nb); else n_pass++;
    n_checks++; if (late_err !== 1'b1) $display("FAIL b2b_late: got %b want 1", late_err); else n_pass++;
    pixel_x = 10'd16; pixel_y = 10'd230;
    tick();
    n_checks++; if (tile_code !== 4'hE) $display("FAIL b2b_row14: got %0d want 14", tile_code); else n_pass++;
  endtask

  task automatic test_reset_clear();
    reset = 1'b0;
    #1;
    n_checks++; if (late_err !== 1'b0 || tile_code !== 4'd0)
      $display("FAIL clear_late: got late=%b code=%0d want 0 0", late_err, tile_code); else n_pass++;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_late();
    pixel_x = 10'd640; pixel_y = 10'd159; hblank_start = 1'b1;
    tick();
    hblank_start = 1'b0;
    pixel_x = 10'd100; pixel_y = 10'd150;
    tick();
    n_checks++; if (tile_code !== 4'd0 || late_err !== 1'b1)
      $display("FAIL late_busy: got code=%0d late=%b want 0 1", tile_code, late_err); else n_pass++;
    pixel_x = 10'd640;
    for (int i = 0; i < 6; i++) tick();
    pixel_x = 10'd100;
    tick();
    n_checks++; if (tile_code !== 4'hA || late_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL late_sticky: got code=%0d late=%b busy=%b want 10 1 0", tile_code, late_err, busy);
    else n_pass++;
  endtask

  task automatic test_wrap();
    int nb;
    logic [4:0] a;
    pulse(463, nb, a);
    n_checks++; if (nb != 3 || a !== 5'd29)
      $display("FAIL wrap_row29: got busy=%0d addr=%0d want 3 and 29", nb, a); else n_pass++;
    pulse(479, nb, a);
    n_checks++; if (nb != 0 || rdaddr !== 5'd29)
      $display("FAIL wrap_line479: got busy=%0d addr=%0d want 0 and 29", nb, rdaddr); else n_pass++;
    pulse(524, nb, a);
    n_checks++; if (nb != 3 || a !== 5'd0)
      $display("FAIL wrap_row0: got busy=%0d addr=%0d want 3 and 0", nb, a); else n_pass++;
  endtask

  task automatic test_random();
    int nb, y, t, r, x, py, want;
    logic [4:0] a;
    model_row = 0;
    for (int i = 0; i < 40; i++) model_buf[i] = mem[0][i];
    for (int rr = 0; rr < 30; rr++)
      for (int i = 0; i < 40; i++) mem[rr][i] = 4'($urandom_range(0, 15));
    for (int it = 0; it < 20; it++) begin
      y = int'($urandom_range(0, 524));
      t = (y == 524) ? 0 : y + 1;
      r = t / 16;
      want = (t < 480 && r != model_row) ? 3 : 0;
      pulse(y, nb, a);
      n_checks++; if (nb != want)
        $display("FAIL rand_fetch_y%0d: got %0d busy cycles want %0d", y, nb, want); else n_pass++;
      if (want == 3) begin
        model_row = r;
        for (int i = 0; i < 40; i++) model_buf[i] = mem[r][i];
      end
      for (int k = 0; k < 3; k++) begin
        x  = int'($urandom_range(0, 700));
        py = int'($urandom_range(0, 500));
        pixel_x = 10'(x); pixel_y = 10'(py);
        tick();
        want = (x >= 640 || py >= 480) ? 0 : int'(model_buf[x/16]);
        n_checks++; if (tile_code !== 4'(want))
          $display("FAIL rand_tile_x%0d_y%0d: got %0d want %0d", x, py, tile_code, want); else n_pass++;
      end
      pixel_x = 10'd640;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int rr = 0; rr < 30; rr++)
      for (int i = 0; i < 40; i++) mem[rr][i] = (rr == 5) ? 4'(i) : 4'(rr);
    test_reset();
    test_skip();
    test_tile_select();
    test_back_to_back();
    test_reset_clear();
    test_late();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
